eth_rx_stat: RTL and testbench

- Parametrised per-channel receive statistics and error monitor for ETHCOUNT MAC receive streams. Supersedes the fixed two-channel good/err pulse logic.
- Tracks frame boundaries, per-frame length, and good/bad/runt/oversize frame counts plus byte totals. Provides sticky error flags and a registered counter read port.
- Sits in the mac_gtx_clk domain, downstream of the mac_rgmii receive outputs, in parallel with the forwarding path. It is observe-only and never back-pressures.

---
 rtl/eth_stat_pkg.sv | 19 +
 rtl/eth_rx_stat_ch.sv | 87 ++++++++
 rtl/eth_rx_stat.sv | 64 ++++++
 tb/tb_eth_rx_stat.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_stat_pkg.sv
// eth_stat_pkg: read-select encodings, channel state and saturating arithmetic for eth_rx_stat
package eth_stat_pkg;
    localparam logic [2:0] SEL_GOOD   = 3'd0;
    localparam logic [2:0] SEL_BAD    = 3'd1;
    localparam logic [2:0] SEL_RUNT   = 3'd2;
    localparam logic [2:0] SEL_LONG   = 3'd3;
    localparam logic [2:0] SEL_BYTES  = 3'd4;
    localparam logic [2:0] SEL_ORPHAN = 3'd5;
    localparam logic [2:0] SEL_LAST   = 3'd6;
    localparam logic [2:0] SEL_ZERO   = 3'd7;

    typedef enum logic {ST_IDLE, ST_IN_FRAME} st_t;

    function automatic logic [47:0] sat_add(input logic [47:0] a, input logic [47:0] b, input logic [47:0] lim);
        logic [48:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[47:0];
    endfunction
endpackage

// File: rtl/eth_rx_stat_ch.sv
// eth_rx_stat_ch: one channel's frame tracker, length counter and saturating statistics
module eth_rx_stat_ch
    import eth_stat_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int LEN_W   = 16,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic             rx_sof,
    input  logic             rx_eof,
    input  logic             rx_fr_good,
    input  logic             rx_fr_err,
    input  logic             clr,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_val,
    output logic             err_det
);
    localparam logic [47:0] CNT_MAX = 48'({CNT_W{1'b1}});

    st_t              st;
    logic [LEN_W-1:0] len, len_inc, clen, badd, last_len;
    logic             frame_err, idle, start, close, abort, bad, orph;
    logic [CNT_W-1:0] cnt_good, cnt_bad, cnt_runt, cnt_long, cnt_bytes, cnt_orph;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic [LEN_W-1:0] k);
        return CNT_W'(sat_add(48'(c), 48'(k), CNT_MAX));
    endfunction

    always_comb begin
        idle    = st == ST_IDLE;
        len_inc = &len ? len : len + LEN_W'(1);
        clen    = idle ? LEN_W'(1) : len_inc;
        start   = rx_valid & rx_sof & ~rx_eof;
        close   = rx_valid & rx_eof & (~idle | rx_sof);
        abort   = start & ~idle;
        bad     = ~rx_fr_good | (~idle & frame_err) | rx_fr_err;
        orph    = idle & rx_fr_err & ~(rx_valid & rx_sof);
        badd    = abort ? len : clen;
    end

    // A sof inside a frame both aborts the old frame and opens the new one
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            st        <= ST_IDLE;
            len       <= '0;
            frame_err <= 1'b0;
            last_len  <= '0;
            cnt_good  <= '0;
            cnt_bad   <= '0;
            cnt_runt  <= '0;
            cnt_long  <= '0;
            cnt_bytes <= '0;
            cnt_orph  <= '0;
            err_det   <= 1'b0;
        end else begin
            st        <= start ? ST_IN_FRAME : close ? ST_IDLE : st;
            len       <= start ? LEN_W'(1) : close ? '0 : (~idle & rx_valid) ? len_inc : len;
            frame_err <= start ? rx_fr_err : close ? 1'b0 : ~idle & (frame_err | rx_fr_err);
            if (close & ~bad) cnt_good <= bump(cnt_good, LEN_W'(1));
            if ((close & bad) | abort) cnt_bad <= bump(cnt_bad, LEN_W'(1));
            if (close && int'(clen) < MIN_LEN) cnt_runt <= bump(cnt_runt, LEN_W'(1));
            if (close && int'(clen) > MAX_LEN) cnt_long <= bump(cnt_long, LEN_W'(1));
            if (close | abort) cnt_bytes <= bump(cnt_bytes, badd);
            if (close) last_len <= clen;
            if (orph) cnt_orph <= bump(cnt_orph, LEN_W'(1));
            if ((close & bad) | abort | orph) err_det <= 1'b1;
        end
    end

    always_comb begin
        rd_val = '0;
        case (rd_sel)
            SEL_GOOD:   rd_val = cnt_good;
            SEL_BAD:    rd_val = cnt_bad;
            SEL_RUNT:   rd_val = cnt_runt;
            SEL_LONG:   rd_val = cnt_long;
            SEL_BYTES:  rd_val = cnt_bytes;
            SEL_ORPHAN: rd_val = cnt_orph;
            SEL_LAST:   rd_val = CNT_W'(last_len);
            SEL_ZERO:   rd_val = '0;
        endcase
    end
endmodule

// File: rtl/eth_rx_stat.sv
// eth_rx_stat: per-channel MAC receive statistics with registered counter read port and sticky error flags
module eth_rx_stat
    import eth_stat_pkg::*;
#(
    parameter int ETHCOUNT = 2,
    parameter int CNT_W    = 32,
    parameter int LEN_W    = 16,
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 1518,
    localparam int CH_W    = ETHCOUNT > 1 ? $clog2(ETHCOUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ETHCOUNT*8-1:0] rx_data,
    input  logic [ETHCOUNT-1:0]   rx_valid,
    input  logic [ETHCOUNT-1:0]   rx_sof,
    input  logic [ETHCOUNT-1:0]   rx_eof,
    input  logic [ETHCOUNT-1:0]   rx_fr_good,
    input  logic [ETHCOUNT-1:0]   rx_fr_err,
    input  logic [ETHCOUNT-1:0]   clr,
    input  logic [CH_W-1:0]       rd_ch,
    input  logic [2:0]            rd_sel,
    output logic [CNT_W-1:0]      rd_data,
    output logic [ETHCOUNT-1:0]   err_det,
    output logic                  err_any
);
    logic [CNT_W-1:0] vals [2**CH_W];
    logic             unused_data;

    assign unused_data = ^rx_data;

    // Unpopulated select codes read as zero so rd_ch >= ETHCOUNT returns 0
    for (genvar i = 0; i < 2**CH_W; i++) begin : g_ch
        if (i < ETHCOUNT) begin : g_on
            eth_rx_stat_ch #(
                .CNT_W(CNT_W), .LEN_W(LEN_W), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)
            ) u_ch (
                .clk(clk),
                .rst(rst),
                .rx_valid(rx_valid[i]),
                .rx_sof(rx_sof[i]),
                .rx_eof(rx_eof[i]),
                .rx_fr_good(rx_fr_good[i]),
                .rx_fr_err(rx_fr_err[i]),
                .clr(clr[i]),
                .rd_sel(rd_sel),
                .rd_val(vals[i]),
                .err_det(err_det[i])
            );
        end else begin : g_off
            assign vals[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            err_any <= 1'b0;
        end else begin
            rd_data <= vals[rd_ch];
            err_any <= |err_det;
        end
    end
endmodule

// File: tb/tb_eth_rx_stat.sv
// tb_eth_rx_stat: directed and randomized checks of eth_rx_stat against a frame-level model
module tb_eth_rx_stat;
    localparam int N = 2;
    localparam int CW = 16;
    localparam longint CMAX = 65535;
    localparam int LMAX = 65535;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*8-1:0] rx_data = '0;
    logic [N-1:0]   rx_valid = '0, rx_sof = '0, rx_eof = '0, rx_fr_good = '0, rx_fr_err = '0, clr = '0;
    logic           rd_ch = 1'b0;
    logic [2:0]     rd_sel = 3'd0;
    logic [CW-1:0]  rd_data;
    logic [N-1:0]   err_det;
    logic           err_any;

    always #5 clk = ~clk;

    eth_rx_stat #(.ETHCOUNT(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_eof(rx_eof), .rx_fr_good(rx_fr_good), .rx_fr_err(rx_fr_err), .clr(clr),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .err_det(err_det), .err_any(err_any)
    );

    int tests = 0, fails = 0;

    // Frame-level model: counters indexed 0 GOOD .. 5 ORPHAN, 6 last length
    bit       open_f [N];
    int       flen [N];
    bit       ferr [N];
    bit       det [N];
    longint   cnt [N][7];
    longint   exp_rd = 0;
    logic [N-1:0] exp_det = '0;
    bit       exp_any = 0;
    bit       chk_en = 0;

    function automatic void check(string nm, longint act, longint want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endfunction

    function automatic void add(int c, int k, longint d);
        cnt[c][k] = (cnt[c][k] + d > CMAX) ? CMAX : cnt[c][k] + d;
    endfunction

    function automatic void wipe(int c);
        open_f[c] = 0; flen[c] = 0; ferr[c] = 0; det[c] = 0;
        for (int k = 0; k < 7; k++) cnt[c][k] = 0;
    endfunction

    function automatic void finish(int c, int l, bit b);
        add(c, b ? 1 : 0, 1);
        if (b) det[c] = 1;
        if (l < 64) add(c, 2, 1);
        if (l > 1518) add(c, 3, 1);
        add(c, 4, l);
        cnt[c][6] = l;
    endfunction

    function automatic void model_step();
        bit v, s, e, g, r;
        exp_rd  = (rst || rd_sel == 3'd7) ? 0 : cnt[rd_ch][rd_sel];
        exp_any = rst ? 0 : (det[0] | det[1]);
        for (int c = 0; c < N; c++) begin
            if (rst || clr[c]) begin
                wipe(c);
                continue;
            end
            v = rx_valid[c]; s = rx_sof[c]; e = rx_eof[c]; g = rx_fr_good[c]; r = rx_fr_err[c];
            if (!open_f[c]) begin
                if (v && s) begin
                    if (e) finish(c, 1, !g || r);
                    else begin open_f[c] = 1; flen[c] = 1; ferr[c] = r; end
                end else if (r) begin
                    add(c, 5, 1);
                    det[c] = 1;
                end
            end else if (v && e) begin
                finish(c, flen[c] + 1 > LMAX ? LMAX : flen[c] + 1, !g || ferr[c] || r);
                open_f[c] = 0; flen[c] = 0; ferr[c] = 0;
            end else if (v && s) begin
                add(c, 1, 1);
                add(c, 4, flen[c]);
                det[c] = 1;
                flen[c] = 1; ferr[c] = r;
            end else begin
                if (v) flen[c] = flen[c] + 1 > LMAX ? LMAX : flen[c] + 1;
                ferr[c] = ferr[c] | r;
            end
        end
        exp_det = {det[1], det[0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        chk_en = 1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_data", rd_data, exp_rd);
            check("err_det", err_det, exp_det);
            check("err_any", err_any, exp_any);
        end
    end

    task automatic quiet();
        rx_valid = '0; rx_sof = '0; rx_eof = '0; rx_fr_good = '0; rx_fr_err = '0; clr = '0;
    endtask

    task automatic beat(int c, bit s, bit e, bit g, bit r);
        rx_valid = '0; rx_sof = '0; rx_eof = '0; rx_fr_good = '0; rx_fr_err = '0;
        rx_valid[c] = 1'b1; rx_sof[c] = s; rx_eof[c] = e; rx_fr_good[c] = g; rx_fr_err[c] = r;
        rx_data = 16'($urandom);
        cyc();
    endtask

    task automatic frame(int c, int n, bit g, bit with_sof, bit with_eof);
        for (int i = 0; i < n; i++) beat(c, with_sof && i == 0, with_eof && i == n - 1, g, 1'b0);
    endtask

    task automatic rd(int c, int s, string nm, longint want);
        quiet();
        rd_ch = c[0]; rd_sel = s[2:0];
        cyc();
        check(nm, rd_data, want);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < N; c++) wipe(c);
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        for (int s = 0; s < 8; s++) rd(0, s, "reset_ch0", 0);

        frame(0, 100, 1, 1, 1);
        rd(0, 0, "good0", 1);
        rd(0, 4, "bytes0", 100);
        rd(0, 6, "last0", 100);
        check("det_after_good", err_det, 0);

        frame(1, 40, 0, 1, 1);
        check("det_bad1", err_det, 2'b10);
        check("any_lag", err_any, 0);
        quiet(); cyc();
        check("any_set", err_any, 1);
        rd(1, 1, "bad1", 1);
        rd(1, 2, "runt1", 1);
        rd(0, 0, "good0_kept", 1);
        rd(0, 1, "bad0_kept", 0);

        clr = '1; cyc(); quiet();
        frame(0, 1600, 1, 1, 1);
        rd(0, 0, "good_long", 1);
        rd(0, 3, "long", 1);
        rd(0, 4, "bytes_long", 1600);
        frame(0, 50, 1, 1, 0);
        beat(0, 1, 0, 1, 0);
        rd(0, 1, "bad_abort", 1);
        rd(0, 4, "bytes_abort", 1650);
        rd(0, 2, "runt_abort", 0);
        frame(0, 63, 1, 0, 1);
        rd(0, 0, "good_after_abort", 2);
        rd(0, 4, "bytes_after_abort", 1714);
        rd(0, 6, "last_after_abort", 64);

        clr = '1; cyc(); quiet();
        rx_fr_err[0] = 1'b1; cyc(); quiet();
        check("det_orphan", err_det, 2'b01);
        rd(0, 5, "orphan", 1);
        frame(0, 20, 1, 1, 0);
        clr[0] = 1'b1;
        beat(0, 0, 1, 1, 0);
        clr = '0;
        for (int s = 0; s < 7; s++) rd(0, s, "clr_ch0", 0);
        check("det_clr", err_det, 0);

        frame(0, 10, 1, 1, 1);
        frame(0, 29, 1, 1, 0);
        rst = 1'b1;
        beat(0, 0, 0, 1, 0);
        rst = 1'b0;
        frame(0, 70, 1, 0, 1);
        for (int s = 0; s < 7; s++) rd(0, s, "rst_midframe", 0);
        frame(0, 64, 1, 1, 1);
        rd(0, 0, "good_post_rst", 1);
        rd(0, 2, "runt_64", 0);

        repeat (3000) begin
            for (int c = 0; c < N; c++) begin
                rx_valid[c]   = ($urandom % 10) < 7;
                rx_sof[c]     = ($urandom % 16) == 0;
                rx_eof[c]     = ($urandom % 24) == 0;
                rx_fr_good[c] = ($urandom % 8) != 0;
                rx_fr_err[c]  = ($urandom % 64) == 0;
                clr[c]        = ($urandom % 400) == 0;
            end
            rst = ($urandom % 1500) == 0;
            rd_ch = 1'($urandom);
            rd_sel = 3'($urandom);
            rx_data = 16'($urandom);
            cyc();
        end
        rst = 1'b0;

        quiet(); clr = '1; cyc(); quiet();
        repeat (70000) begin
            rx_valid = '1; rx_sof = '1; rx_eof = '1; rx_fr_good = 2'b01; rx_fr_err = '0;
            rd_ch = 1'($urandom);
            rd_sel = 3'($urandom);
            cyc();
        end
        rd(0, 0, "good_sat", 65535);
        rd(0, 4, "bytes_sat", 65535);
        rd(0, 2, "runt_sat", 65535);
        rd(0, 6, "last_sat", 1);
        rd(1, 1, "bad_sat", 65535);
        rd(1, 0, "good1_sat", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
